// File: rtl/fila_pkg.sv
// Shared types and constants for the fila queue scheduler.
package fila_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ENQ       = 3'd1,
      DEQ_ISSUE = 3'd2,
      DEQ_WAIT  = 3'd3,
      DEQ_DONE  = 3'd4
   } state_t;

   typedef enum logic {
      PUSH = 1'b0,
      POP  = 1'b1
   } last_op_t;

   // Cycles between the queue dequeue strobe and a stable data_out
   localparam int unsigned DEQ_WAIT_CYCLES = 3;
   localparam int unsigned WAIT_CNT_W      = $clog2(DEQ_WAIT_CYCLES);

endpackage

// File: rtl/fila_sched_if.sv
// Producer/consumer side of the fila scheduler: N_REQ push ports and one pop port.
interface fila_sched_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 8
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_ack;
   logic                pop_req;
   logic                pop_valid;
   logic [DW-1:0]       pop_data;

   modport master (
      output req_valid, req_data, pop_req,
      input  req_ack, pop_valid, pop_data
   );

   modport slave (
      input  req_valid, req_data, pop_req,
      output req_ack, pop_valid, pop_data
   );
endinterface

// File: rtl/fila_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] grant_c,
   output logic             any_req_c
);

   logic [IDX_W:0] sum_c;
   logic [IDX_W-1:0] idx_c;

   always_comb begin
      grant_c   = '0;
      any_req_c = 1'b0;
      sum_c     = '0;
      idx_c     = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         sum_c = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (sum_c >= (IDX_W+1)'(N_REQ)) begin
            sum_c = sum_c - (IDX_W+1)'(N_REQ);
         end
         idx_c = IDX_W'(sum_c);
         if (!any_req_c && req[idx_c]) begin
            any_req_c = 1'b1;
            grant_c   = idx_c;
         end
      end
   end

endmodule

// File: rtl/fila_sched.sv
// Round-robin push / pop scheduler in front of the 8-entry fila byte queue.
// Optional FILA_SCHED_CHECK_EN: sticky err when q_len disagrees with the shadow count.
module fila_sched
   import fila_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk_10KHz,
   input  logic             reset,
   fila_sched_if.slave      bus,
   output logic [DW-1:0]    q_data_in,
   output logic             q_enqueue,
   output logic             q_dequeue,
   input  logic [DW-1:0]    q_data_out,
   input  logic [7:0]       q_len,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   state_t                state, state_nxt;
   last_op_t              last_op;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      grant_c;
   logic                  any_req_c;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  push_ok_c, pop_ok_c;
   logic [DW-1:0]         req_bytes [N_REQ];

   for (genvar g = 0; g < int'(N_REQ); g++) begin : g_bytes
      assign req_bytes[g] = bus.req_data[g*DW +: DW];
   end

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant_c   (grant_c),
      .any_req_c (any_req_c)
   );

   assign push_ok_c = any_req_c & ~full;
   assign pop_ok_c  = bus.pop_req & ~empty;

   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // On a push/pop tie the operation type not used last goes first
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (push_ok_c && (!pop_ok_c || last_op == POP)) state_nxt = ENQ;
            else if (pop_ok_c)                             state_nxt = DEQ_ISSUE;
         end
         ENQ:       state_nxt = IDLE;
         DEQ_ISSUE: state_nxt = DEQ_WAIT;
         DEQ_WAIT:  if (wait_cnt == '0) state_nxt = DEQ_DONE;
         DEQ_DONE:  state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Registered strobes are launched on the edge that enters the owning state
   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         bus.req_ack   <= '0;
         bus.pop_valid <= 1'b0;
         bus.pop_data  <= '0;
         q_data_in     <= '0;
         q_enqueue     <= 1'b0;
         q_dequeue     <= 1'b0;
         count         <= '0;
         full          <= 1'b0;
         empty         <= 1'b1;
         rr_ptr        <= '0;
         last_op       <= POP;
         wait_cnt      <= '0;
      end else begin
         bus.req_ack   <= '0;
         bus.pop_valid <= 1'b0;
         q_enqueue     <= 1'b0;
         q_dequeue     <= 1'b0;

         if (state == IDLE && state_nxt == ENQ) begin
            bus.req_ack <= N_REQ'(1) << grant_c;
            q_data_in   <= req_bytes[grant_c];
            q_enqueue   <= 1'b1;
            rr_ptr      <= (grant_c == IDX_W'(N_REQ - 1)) ? '0 : grant_c + IDX_W'(1);
            last_op     <= PUSH;
            count       <= count + CNT_W'(1);
            full        <= (count + CNT_W'(1) == CNT_W'(DEPTH));
            empty       <= 1'b0;
         end

         if (state == IDLE && state_nxt == DEQ_ISSUE) begin
            q_dequeue <= 1'b1;
            last_op   <= POP;
         end

         if (state == DEQ_ISSUE) begin
            wait_cnt <= WAIT_CNT_W'(DEQ_WAIT_CYCLES - 1);
         end

         if (state == DEQ_WAIT) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            if (wait_cnt == '0) begin
               bus.pop_data  <= q_data_out;
               bus.pop_valid <= 1'b1;
               count         <= count - CNT_W'(1);
               full          <= 1'b0;
               empty         <= (count == CNT_W'(1));
            end
         end
      end
   end

`ifdef FILA_SCHED_CHECK_EN
   logic idle_d;

   // First IDLE cycle is skipped because len_out trails the last operation
   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         idle_d <= 1'b0;
         err    <= 1'b0;
      end else begin
         idle_d <= (state == IDLE);
         if (state == IDLE && idle_d && q_len != 8'(count)) err <= 1'b1;
      end
   end
`else
   logic unused_q_len;
   assign unused_q_len = ^q_len;
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fila_sched.sv
// Directed, table-driven bench for fila_sched with a behavioural model of the fila queue.
module tb_fila_sched;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk_10KHz = 1'b0;
   logic             reset = 1'b1;
   logic [DW-1:0]    q_data_in;
   logic             q_enqueue;
   logic             q_dequeue;
   logic [DW-1:0]    q_data_out;
   logic [7:0]       q_len;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             err;

   int errors = 0;
   int checks = 0;
   bit overlap_seen = 1'b0;

   always #5 clk_10KHz = ~clk_10KHz;

   fila_sched_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

   fila_sched #(.N_REQ(N_REQ), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk_10KHz  (clk_10KHz),
      .reset      (reset),
      .bus        (bus),
      .q_data_in  (q_data_in),
      .q_enqueue  (q_enqueue),
      .q_dequeue  (q_dequeue),
      .q_data_out (q_data_out),
      .q_len      (q_len),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .err        (err)
   );

   // Queue model: data_out and len_out follow one edge after the strobe
   logic [7:0] qmem [$];
   always @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         qmem.delete();
         q_data_out <= '0;
         q_len      <= '0;
      end else begin
         if (q_enqueue) qmem.push_back(q_data_in);
         if (q_dequeue && qmem.size() > 0) q_data_out <= qmem.pop_front();
         q_len <= 8'(qmem.size());
      end
   end

   always @(negedge clk_10KHz) begin
      if (q_enqueue && q_dequeue) overlap_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.pop_req   = 1'b0;
      bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (2) @(negedge clk_10KHz);
      reset = 1'b0;
      @(negedge clk_10KHz);
   endtask

   task automatic push_one(input int p, input logic [7:0] b, output int lat);
      lat = -1;
      bus.req_data[p*8 +: 8] = b;
      bus.req_valid = 4'(1 << p);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_10KHz);
         if (bus.req_ack[p]) begin
            lat = i;
            break;
         end
      end
      bus.req_valid = '0;
      if (lat < 0) chk("push_one_timeout", 0, 1);
   endtask

   typedef struct {
      logic [3:0] valid;
      logic       pop;
      logic       exp_push;
      logic [3:0] exp_ack;
      logic [7:0] exp_byte;
      logic [3:0] exp_count;
   } vec_t;

   vec_t vecs [22];

   task automatic run_vec(input int i);
      bit hit = 1'b0;
      bus.req_valid = vecs[i].valid;
      bus.pop_req   = vecs[i].pop;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_10KHz);
         if (bus.req_ack != '0 || bus.pop_valid) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         chk($sformatf("vec%0d_timeout", i), 0, 1);
      end else begin
         if (vecs[i].exp_push) begin
            chk($sformatf("vec%0d_ack", i), 32'(bus.req_ack), 32'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_q_enqueue", i), 32'(q_enqueue), 1);
            chk($sformatf("vec%0d_q_data_in", i), 32'(q_data_in), 32'(vecs[i].exp_byte));
         end else begin
            chk($sformatf("vec%0d_pop_valid", i), 32'(bus.pop_valid), 1);
            chk($sformatf("vec%0d_pop_data", i), 32'(bus.pop_data), 32'(vecs[i].exp_byte));
            chk($sformatf("vec%0d_no_ack", i), 32'(bus.req_ack), 0);
         end
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_count == 4'd8));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_count == 4'd0));
      end
   endtask

   initial begin
      int lat;
      int n_ack, n_enq, n_deq, n_pv;
      int first_deq, second_deq;
      int pv_at [2];
      logic [7:0] pv_data [2];

      // fairness: all producers held valid
      vecs[0]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd1};
      vecs[1]  = '{4'hF, 1'b0, 1'b1, 4'b0010, 8'h11, 4'd2};
      vecs[2]  = '{4'hF, 1'b0, 1'b1, 4'b0100, 8'h12, 4'd3};
      vecs[3]  = '{4'hF, 1'b0, 1'b1, 4'b1000, 8'h13, 4'd4};
      vecs[4]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd5};
      // fill to DEPTH, then one pop lets the waiting request in
      vecs[5]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd1};
      vecs[6]  = '{4'hF, 1'b0, 1'b1, 4'b0010, 8'h11, 4'd2};
      vecs[7]  = '{4'hF, 1'b0, 1'b1, 4'b0100, 8'h12, 4'd3};
      vecs[8]  = '{4'hF, 1'b0, 1'b1, 4'b1000, 8'h13, 4'd4};
      vecs[9]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd5};
      vecs[10] = '{4'hF, 1'b0, 1'b1, 4'b0010, 8'h11, 4'd6};
      vecs[11] = '{4'hF, 1'b0, 1'b1, 4'b0100, 8'h12, 4'd7};
      vecs[12] = '{4'hF, 1'b0, 1'b1, 4'b1000, 8'h13, 4'd8};
      vecs[13] = '{4'hF, 1'b1, 1'b0, 4'b0000, 8'h10, 4'd7};
      vecs[14] = '{4'hF, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd8};
      // three pushes, then push and pop both pending: they alternate
      vecs[15] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 8'h10, 4'd1};
      vecs[16] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 8'h11, 4'd2};
      vecs[17] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 8'h12, 4'd3};
      vecs[18] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 8'h10, 4'd2};
      vecs[19] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 8'h13, 4'd3};
      vecs[20] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 8'h11, 4'd2};
      vecs[21] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 8'h13, 4'd3};

      // reset values
      do_reset();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ack", 32'(bus.req_ack), 0);
      chk("rst_pop_valid", 32'(bus.pop_valid), 0);
      chk("rst_pop_data", 32'(bus.pop_data), 0);
      chk("rst_q_enqueue", 32'(q_enqueue), 0);
      chk("rst_q_dequeue", 32'(q_dequeue), 0);
      chk("rst_q_data_in", 32'(q_data_in), 0);

      // single push from producer 2
      bus.req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
      push_one(2, 8'hA5, lat);
      chk("single_latency", 32'(lat), 1);
      chk("single_ack", 32'(bus.req_ack), 32'h4);
      chk("single_q_enqueue", 32'(q_enqueue), 1);
      chk("single_q_data_in", 32'(q_data_in), 32'hA5);
      chk("single_count", 32'(count), 1);
      chk("single_empty", 32'(empty), 0);
      @(negedge clk_10KHz);
      chk("single_enq_pulse", 32'(q_enqueue), 0);
      chk("single_ack_pulse", 32'(bus.req_ack), 0);

      do_reset();
      for (int i = 0; i <= 4; i++) run_vec(i);

      // full: the 9th request is held off
      do_reset();
      for (int i = 5; i <= 12; i++) run_vec(i);
      n_ack = 0;
      n_enq = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_10KHz);
         if (bus.req_ack != '0) n_ack++;
         if (q_enqueue) n_enq++;
      end
      chk("full_no_ack", 32'(n_ack), 0);
      chk("full_no_enqueue", 32'(n_enq), 0);
      chk("full_flag", 32'(full), 1);
      for (int i = 13; i <= 14; i++) run_vec(i);
      bus.req_valid = '0;

      // pop latency and order
      do_reset();
      push_one(1, 8'h11, lat);
      push_one(1, 8'h22, lat);
      @(negedge clk_10KHz);
      bus.pop_req = 1'b1;
      n_deq = 0;
      n_pv = 0;
      first_deq = -1;
      second_deq = -1;
      pv_at[0] = -1;
      pv_at[1] = -1;
      pv_data[0] = '0;
      pv_data[1] = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_10KHz);
         if (q_dequeue) begin
            if (n_deq == 0) first_deq = c;
            if (n_deq == 1) second_deq = c;
            n_deq++;
         end
         if (bus.pop_valid) begin
            if (n_pv < 2) begin
               pv_at[n_pv] = c;
               pv_data[n_pv] = bus.pop_data;
            end
            n_pv++;
         end
      end
      bus.pop_req = 1'b0;
      chk("pop_deq_latency", 32'(first_deq), 1);
      chk("pop_valid_latency", 32'(pv_at[0]), 5);
      chk("pop_first_data", 32'(pv_data[0]), 32'h11);
      chk("pop_second_deq", 32'(second_deq), 7);
      chk("pop_second_valid", 32'(pv_at[1]), 11);
      chk("pop_second_data", 32'(pv_data[1]), 32'h22);
      chk("pop_empty_no_deq", 32'(n_deq), 2);
      chk("pop_valid_total", 32'(n_pv), 2);
      chk("pop_data_held", 32'(bus.pop_data), 32'h22);
      chk("pop_final_empty", 32'(empty), 1);

      // alternation with count=3
      do_reset();
      for (int i = 15; i <= 21; i++) run_vec(i);
      bus.req_valid = '0;
      bus.pop_req = 1'b0;
      repeat (6) @(negedge clk_10KHz);
      chk("alt_count", 32'(count), 3);
      chk("alt_err", 32'(err), 0);

      // reset while waiting for queue data
      do_reset();
      push_one(0, 8'h5A, lat);
      @(negedge clk_10KHz);
      bus.pop_req = 1'b1;
      repeat (3) @(negedge clk_10KHz);
      reset = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_pop_valid", 32'(bus.pop_valid), 0);
      chk("mid_rst_pop_data", 32'(bus.pop_data), 0);
      chk("mid_rst_q_data_in", 32'(q_data_in), 0);
      chk("mid_rst_q_dequeue", 32'(q_dequeue), 0);
      chk("mid_rst_err", 32'(err), 0);
      bus.pop_req = 1'b0;
      @(negedge clk_10KHz);
      reset = 1'b0;
      n_pv = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_10KHz);
         if (bus.pop_valid) n_pv++;
      end
      chk("mid_rst_no_pop_valid", 32'(n_pv), 0);
      chk("mid_rst_count_after", 32'(count), 0);
      push_one(3, 8'h3C, lat);
      chk("mid_rst_push_latency", 32'(lat), 1);
      chk("mid_rst_push_data", 32'(q_data_in), 32'h3C);
      chk("mid_rst_push_count", 32'(count), 1);

      chk("no_enq_deq_overlap", 32'(overlap_seen), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fila_sched.md
# fila_sched

Scheduler in front of the 8-entry byte queue (`fila`). It arbitrates up to N_REQ producers with round-robin fairness and serialises their pushes with consumer pops, so the queue only sees one operation at a time and only while it is idle. It keeps a shadow occupancy count, because the queue's `len_out` lags the real fill level. It also absorbs the queue's fixed four-cycle dequeue sequence and returns each popped byte with a one-cycle valid pulse.

## Interface
Parameters:
- N_REQ, 4, number of producers (2..8)
- DEPTH, 8, queue depth; must match the queue
- DW, 8, data width

Ports:
- clk_10KHz  in  1  clock
- reset  in  1  asynchronous, active-high; the same net drives the queue's reset
- req_valid  in  N_REQ  per-producer push request, level, held until acked
- req_data  in  N_REQ*DW  producer i data at bits [i*DW +: DW]
- req_ack  out  N_REQ  one-cycle pulse when producer i's byte is pushed
- pop_req  in  1  consumer pop request, level, held until pop_valid
- pop_valid  out  1  one-cycle pulse; pop_data valid
- pop_data  out  DW  popped byte, held until the next pop
- q_data_in  out  DW  to queue `data_in`
- q_enqueue  out  1  to queue `enqueue_in`
- q_dequeue  out  1  to queue `dequeue_in`
- q_data_out  in  DW  from queue `data_out`
- q_len  in  8  from queue `len_out`
- count  out  $clog2(DEPTH+1)  shadow occupancy
- full, empty  out  1  count==DEPTH, count==0
- err  out  1  sticky length-mismatch flag (see Configuration)

## Operation
- States: IDLE, ENQ, DEQ_ISSUE, DEQ_WAIT, DEQ_DONE.
- Push is eligible when any req_valid is high and full is low. Pop is eligible when pop_req is high and empty is low.
- **IDLE**
  - Only push eligible: go to ENQ.
  - Only pop eligible: go to DEQ_ISSUE.
  - Both eligible: pick the opposite of the last operation type; last_op resets to POP, so push wins first.
- **ENQ** (1 cycle)
  - q_enqueue=1 and q_data_in=req_data[grant].
  - req_ack[grant]=1 and count+1.
  - rr_ptr=(grant+1) mod N_REQ.
  - Next state IDLE.
- **Grant selection:** the lowest index ≥ rr_ptr with req_valid high, wrapping; it is latched on the IDLE→ENQ transition.
- **DEQ_ISSUE** (1 cycle): q_dequeue=1, then DEQ_WAIT.
- **DEQ_WAIT** (3 cycles, counted by a down-counter): at the last cycle pop_data<=q_data_out and count-1, then DEQ_DONE.
- **DEQ_DONE** (1 cycle): pop_valid=1, then IDLE.
- Outside ENQ and DEQ_ISSUE, q_enqueue and q_dequeue are 0; q_enqueue and q_dequeue are never both 1.
- If req_valid drops while the block is in ENQ, the push still completes; producers must hold req_valid until ack.
- count never wraps: no push at DEPTH, no pop at 0. Ineligible requests wait; they are not dropped.

## Timing
- Push: 2 cycles, IDLE→ENQ→IDLE. Back-to-back pushes are accepted every 2 cycles.
- Pop: pop_req seen in IDLE at cycle t.
  - q_dequeue at t+1.
  - Queue data_out is stable by t+3 and sampled at t+4.
  - pop_valid at t+5.
  - The next operation can be issued at t+7, when the queue is back in its wait state.
- Reset values:
  - state=IDLE, count=0, rr_ptr=0, last_op=POP.
  - req_ack=0, pop_valid=0, pop_data=0.
  - q_enqueue=0, q_dequeue=0, q_data_in=0.
  - err=0, empty=1, full=0.
- Reset mid-operation, including during DEQ_WAIT: immediate return to IDLE with no ack or pop_valid. The queue is reset on the same net, so both sides restart empty.

## Configuration
- FILA_SCHED_CHECK_EN defined: while in IDLE for the 2nd or later consecutive cycle, the block compares q_len with zero-extended count. On a mismatch err is set and stays set until reset. The one-cycle IDLE skip covers the `len_out` lag.
- Not defined: err is tied to 0, and q_len is unused.

## Structure
- Package fila_pkg holds:
  - state_t enum
  - DEQ_WAIT_CYCLES=3
  - last-op enum {PUSH, POP}
- Sub-module rr_arbiter holds the combinational round-robin pick from (req vector, rr_ptr). It outputs grant index and any_req.

## Test plan
- **Single push:** reset, then producer 2 drives 0xA5 → q_enqueue for 1 cycle with 0xA5, req_ack[2] pulse, count=1, empty=0.
- **Fairness:** all 4 producers held valid with data 0x10..0x13 → ack order 0,1,2,3,0, count reaches 5.
- **Full:** push 8 bytes, then a 9th request → full=1, no 9th ack. After one pop the 9th is acked and count returns to 8.
- **Pop latency and order:** push 0x11, 0x22, then hold pop_req → pop_valid 5 cycles after IDLE sees pop_req with 0x11, then 0x22. Pop at empty gives no q_dequeue.
- **Simultaneous push and pop with count=3:** operations alternate push, pop, push, pop. With FILA_SCHED_CHECK_EN, err stays 0.
- **Reset asserted in DEQ_WAIT** → IDLE, count=0, no pop_valid, all outputs at reset values.
